// File: rtl/ctrl_pkg.sv
// Shared types for the stack-walk controller: FSM state encoding and error codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD     = 4'd1,
    MULT     = 4'd2,
    WAIT_UPD = 4'd3,
    ALU      = 4'd4,
    BACK     = 4'd5,
    PUSH     = 4'd6,
    POP      = 4'd7,
    POPER    = 4'd8,
    DONE     = 4'd9,
    ERR      = 4'd10
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

endpackage

// File: rtl/stack_walk_ctrl_counter.sv
// Up-counter with synchronous clear and terminal-count compare; used for phase timing.
module cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_term = (r_cnt == i_term);

endmodule

// File: rtl/stack_walk_ctrl.sv
// Stack-walk search controller: sequences datapath phases and owns the stack pointer.
module stack_walk_ctrl
  import ctrl_pkg::*;
#(
  parameter  int DEPTH    = 16,
  parameter  int WAIT_MAX = 255,
  parameter  int MULT_CYC = 1,
  localparam int SP_W     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            updated,
  input  logic            backtrack,
  input  logic            abort,
  output logic            load_init,
  output logic            updater,
  output logic            alu,
  output logic            res_updater,
  output logic            cal_res,
  output logic            poping,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [1:0]      err_code,
  output logic [SP_W-1:0] sp
);

  localparam int TO_W = $clog2(WAIT_MAX + 1);
  localparam int MC_W = $clog2(MULT_CYC + 1);
  localparam logic [SP_W-1:0] SP_MAX  = SP_W'(DEPTH);
  localparam logic [TO_W-1:0] TO_TERM = TO_W'(WAIT_MAX - 1);
  localparam logic [MC_W-1:0] MC_TERM = MC_W'(MULT_CYC - 1);

  state_t          r_state;
  state_t          w_next;
  logic [SP_W-1:0] r_sp;
  logic [1:0]      r_err;
  logic            w_mc_term;
  logic            w_to_term;
  logic            w_sp_full;
  logic            w_sp_empty;

  assign w_sp_full  = (r_sp == SP_MAX);
  assign w_sp_empty = (r_sp == '0);

  // Counters restart whenever their phase is (re)entered.
  cycle_counter #(.W(MC_W)) u_mult_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != MULT),
    .i_en   (r_state == MULT),
    .i_term (MC_TERM),
    .o_term (w_mc_term)
  );

  cycle_counter #(.W(TO_W)) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != WAIT_UPD),
    .i_en   (r_state == WAIT_UPD),
    .i_term (TO_TERM),
    .o_term (w_to_term)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = LOAD;
      LOAD:     w_next = MULT;
      MULT:     if (w_mc_term) w_next = WAIT_UPD;
      WAIT_UPD: begin
        if (updated)        w_next = ALU;
        else if (w_to_term) w_next = ERR;
      end
      ALU:      w_next = BACK;
      BACK: begin
        if (backtrack)      w_next = POP;
        else if (w_sp_full) w_next = ERR;
        else                w_next = PUSH;
      end
      PUSH:     w_next = MULT;
      POP:      w_next = w_sp_empty ? DONE : POPER;
      POPER:    w_next = POP;
      DONE:     w_next = IDLE;
      ERR:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  // Abort freezes sp and err_code so software can inspect where the walk stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_err <= ERR_NONE;
    end else if (!abort) begin
      case (r_state)
        IDLE: if (start) begin
          r_sp  <= '0;
          r_err <= ERR_NONE;
        end
        WAIT_UPD: if (!updated && w_to_term) r_err <= ERR_TIMEOUT;
        BACK:     if (!backtrack && w_sp_full) r_err <= ERR_OVERFLOW;
        PUSH:     if (!w_sp_full) r_sp <= r_sp + 1'b1;
        POPER:    if (!w_sp_empty) r_sp <= r_sp - 1'b1;
        default:  ;
      endcase
    end
  end

  assign load_init   = (r_state == LOAD);
  assign updater     = (r_state == WAIT_UPD);
  assign alu         = (r_state == ALU);
  assign res_updater = (r_state == PUSH);
  assign cal_res     = (r_state == POP);
  assign poping      = (r_state == POPER);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign error       = (r_state == ERR);
  assign err_code    = r_err;
  assign sp          = r_sp;

endmodule

// File: tb/tb_stack_walk_ctrl.sv
// Self-checking bench for stack_walk_ctrl (DEPTH=4, WAIT_MAX=8, MULT_CYC=2).
module tb_stack_walk_ctrl;

  localparam int TD  = 4;
  localparam int TWM = 8;
  localparam int TMC = 2;

  localparam logic [8:0] SL = 9'h100, SU = 9'h080, SA = 9'h040, SR = 9'h020,
                         SC = 9'h010, SP = 9'h008, SB = 9'h004, SD = 9'h002, SE = 9'h001;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, updated = 1'b0, backtrack = 1'b0, abort = 1'b0;
  logic load_init, updater, alu, res_updater, cal_res, poping, busy, done, error;
  logic [1:0] err_code;
  logic [2:0] sp;
  logic [8:0] strb;

  int n_pass = 0;
  int n_total = 0;
  int w[TD+1];

  stack_walk_ctrl #(.DEPTH(TD), .WAIT_MAX(TWM), .MULT_CYC(TMC)) dut (
    .clk(clk), .rst(rst), .start(start), .updated(updated), .backtrack(backtrack),
    .abort(abort), .load_init(load_init), .updater(updater), .alu(alu),
    .res_updater(res_updater), .cal_res(cal_res), .poping(poping), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .sp(sp)
  );

  always #5 clk = ~clk;

  assign strb = {load_init, updater, alu, res_updater, cal_res, poping, busy, done, error};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic       rst, start, updated, backtrack, abort;
    logic [8:0] st;
    logic [2:0] sp;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[13];

  // Transaction-level model: predicts the outcome of one run from waits w[] and
  // the iteration k at which backtrack is signalled; the bench reacts to the DUT.
  task automatic run_scn(input string tag, input int k, input bit hold);
    int e_upd = 0, e_alu = 0, e_push = 0, e_pop = 0, e_poper = 0;
    int e_done = 0, e_err = 0, e_code = 0, e_sp = 0, e_cyc = 1;
    int a_upd = 0, a_alu = 0, a_push = 0, a_pop = 0, a_poper = 0;
    int a_done = 0, a_err = 0, a_cyc = 0, a_load = 0, a_bad = 0, a_sp = 0, a_code = 0;
    int wc = 0, iter = 0;
    bit fin = 0;
    for (int i = 0; i <= TD; i++) begin
      e_cyc += TMC;
      if (w[i] > TWM) begin
        e_cyc += TWM + 1; e_upd += TWM; e_err = 1; e_code = 1; e_sp = i;
        break;
      end
      e_cyc += w[i] + 2; e_upd += w[i]; e_alu++;
      if (i == k) begin
        e_pop = i + 1; e_poper = i; e_cyc += 2 * i + 2; e_done = 1; e_sp = 0;
        break;
      end
      if (i == TD) begin
        e_cyc += 1; e_err = 1; e_code = 2; e_sp = TD;
        break;
      end
      e_push++; e_cyc += 1;
    end
    start = 1'b1; updated = 1'b0; backtrack = (k == 0);
    for (int c = 0; c < 600 && !fin; c++) begin
      tick();
      if (!hold) start = 1'b0;
      a_cyc   += busy;     a_load  += load_init; a_upd  += updater;
      a_alu   += alu;      a_push  += res_updater; a_pop += cal_res;
      a_poper += poping;   a_done  += done;      a_err  += error;
      if ($countones({strb[8:3], strb[1:0]}) > 1) a_bad++;
      if (updater) begin wc++; updated = (wc == w[iter]); end
      else begin wc = 0; updated = 1'b0; end
      if (res_updater) iter++;
      backtrack = (iter == k);
      if (done || error) begin
        fin = 1; a_sp = sp; a_code = err_code; start = 1'b0;
      end
    end
    chk({tag, "_finished"}, fin, 1);
    chk({tag, "_sp"}, a_sp, e_sp);
    chk({tag, "_err_code"}, a_code, e_code);
    chk({tag, "_updater_cycles"}, a_upd, e_upd);
    chk({tag, "_alu"}, a_alu, e_alu);
    chk({tag, "_push"}, a_push, e_push);
    chk({tag, "_cal_res"}, a_pop, e_pop);
    chk({tag, "_poping"}, a_poper, e_poper);
    chk({tag, "_done"}, a_done, e_done);
    chk({tag, "_error"}, a_err, e_err);
    chk({tag, "_busy_cycles"}, a_cyc, e_cyc);
    chk({tag, "_load_init"}, a_load, 1);
    chk({tag, "_onehot"}, a_bad, 0);
    updated = 1'b0; backtrack = 1'b0;
    tick();
    chk({tag, "_idle_after"}, int'(strb), 0);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 9'h000,  3'd0, 2'd0};
    tbl[1]  = '{0, 1, 0, 0, 0, SL | SB, 3'd0, 2'd0};
    tbl[2]  = '{0, 0, 0, 0, 0, SB,      3'd0, 2'd0};
    tbl[3]  = '{0, 0, 0, 0, 0, SB,      3'd0, 2'd0};
    tbl[4]  = '{0, 0, 0, 0, 0, SU | SB, 3'd0, 2'd0};
    tbl[5]  = '{0, 0, 1, 0, 0, SA | SB, 3'd0, 2'd0};
    tbl[6]  = '{0, 0, 0, 1, 0, SB,      3'd0, 2'd0};
    tbl[7]  = '{0, 0, 0, 1, 0, SC | SB, 3'd0, 2'd0};
    tbl[8]  = '{0, 0, 0, 0, 0, SD | SB, 3'd0, 2'd0};
    tbl[9]  = '{0, 0, 0, 0, 0, 9'h000,  3'd0, 2'd0};
    tbl[10] = '{0, 1, 0, 0, 1, 9'h000,  3'd0, 2'd0};
    tbl[11] = '{0, 1, 0, 0, 0, SL | SB, 3'd0, 2'd0};
    tbl[12] = '{0, 0, 0, 0, 1, 9'h000,  3'd0, 2'd0};

    tick(); tick();
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; updated = tbl[i].updated;
      backtrack = tbl[i].backtrack; abort = tbl[i].abort;
      tick();
      chk($sformatf("vec%0d_strobes", i), int'(strb), int'(tbl[i].st));
      chk($sformatf("vec%0d_sp", i), int'(sp), int'(tbl[i].sp));
      chk($sformatf("vec%0d_err_code", i), int'(err_code), int'(tbl[i].ec));
    end
    rst = 0; start = 0; updated = 0; backtrack = 0; abort = 0;
    tick();

    // Nominal descend x3 then unwind.
    for (int j = 0; j <= TD; j++) w[j] = 1;
    run_scn("nominal", 3, 0);
    // updated never asserted: timeout.
    w[0] = TWM + 1;
    run_scn("timeout", 0, 0);
    // updated on the last allowed WAIT cycle wins over timeout.
    w[0] = TWM;
    run_scn("upd_vs_timeout", 0, 0);
    // Never backtrack: overflow, then a new start clears err_code.
    for (int j = 0; j <= TD; j++) w[j] = 1;
    run_scn("overflow", TD + 1, 0);
    start = 1'b1;
    tick();
    chk("ovf_restart_load", load_init, 1);
    chk("ovf_restart_err_clear", err_code, 0);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    // start held high through the whole run.
    run_scn("held_start", 2, 1);

    // Abort in MULT with sp=1.
    begin
      bit found = 0;
      int pulses = 0;
      start = 1'b1;
      for (int c = 0; c < 100; c++) begin
        tick();
        start = 1'b0;
        updated = updater;
        if (res_updater) begin found = 1; break; end
      end
      chk("abort_reach_push", found, 1);
      updated = 1'b0;
      tick();
      chk("abort_in_mult_state", int'(strb), int'(SB));
      chk("abort_in_mult_sp", sp, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", int'(strb), 0);
      chk("abort_sp_kept", sp, 1);
      chk("abort_err_kept", err_code, 0);
      for (int c = 0; c < 4; c++) begin
        tick();
        pulses += done + error + busy;
      end
      chk("abort_no_pulse", pulses, 0);
    end

    // Reset mid-run in WAIT_UPD with sp=2; rst beats start/abort/updated.
    begin
      bit found = 0;
      start = 1'b1;
      for (int c = 0; c < 200; c++) begin
        tick();
        start = 1'b0;
        if (updater && sp == 3'd2) begin found = 1; break; end
        updated = updater;
      end
      chk("rst_reach_wait_sp2", found, 1);
      rst = 1'b1; start = 1'b1; abort = 1'b1; updated = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; abort = 1'b0; updated = 1'b0;
      chk("rst_strobes", int'(strb), 0);
      chk("rst_sp", sp, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_code", err_code, 0);
    end

    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j <= TD; j++)
        w[j] = ($urandom_range(0, 7) == 0) ? TWM + 1 : int'($urandom_range(1, TWM));
      run_scn($sformatf("rand%0d", r), int'($urandom_range(0, TD + 1)), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
